full_adder_8bits: RTL and testbench
===================================

Name: full_adder_8bits

Overview:
- Registered 8-bit binary adder: sum = s0 + s1 + cin, with carry-out and status flags.
- Datapath is a ripple chain of WIDTH single-bit full-adder cells, followed by one output register stage.
- Used as a leaf arithmetic block; a downstream consumer samples results qualified by out_valid.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 2. All values in this spec assume the default.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  s0/s1/cin hold a valid operation this cycle.
- s0  input  WIDTH  addend A, unsigned or two's complement.
- s1  input  WIDTH  addend B, unsigned or two's complement.
- cin  input  1  carry-in.
- sum  output  WIDTH  registered result bits [WIDTH-1:0].
- cout  output  1  registered carry-out of the MSB cell (unsigned overflow).
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  registered; 1 when sum == 0.
- out_valid  output  1  registered; sum/cout/overflow/zero correspond to an accepted operation.

Behaviour:
- Combinational core:
  - c[0] = cin.
  - For each bit i: sum_c[i] = s0[i] ^ s1[i] ^ c[i]; c[i+1] = (s0[i] & s1[i]) | (c[i] & (s0[i] ^ s1[i])).
  - cout_c = c[WIDTH]; ovf_c = c[WIDTH] ^ c[WIDTH-1].
  - Full result {cout, sum} equals the exact (WIDTH+1)-bit value s0 + s1 + cin. No saturation; the sum wraps modulo 2^WIDTH.
- Register stage, at each rising clk edge:
  - If rst = 1: sum = 0, cout = 0, overflow = 0, zero = 0, out_valid = 0. Reset takes priority over in_valid.
  - Else if in_valid = 1: sum, cout and overflow load the combinational results; zero loads (sum_c == 0); out_valid = 1.
  - Else: out_valid = 0, and sum/cout/overflow/zero hold their previous values.
- Latency: exactly 1 cycle from an in_valid sample to out_valid plus result. Throughput: one operation per cycle, no backpressure.
- Back-to-back valid inputs produce back-to-back results in order.
- Reset mid-stream: an operation sampled in the same cycle that rst is high is discarded. The first valid input after rst deasserts yields a result one cycle later.
- Inputs are don't-care while in_valid = 0; X on them must not propagate to the outputs.
- No internal state other than the output registers. No combinational path from inputs to outputs.

Test Plan:
- Apply rst for 2 cycles with in_valid = 1 and arbitrary operands -> sum = 0x00, cout = 0, overflow = 0, zero = 0, out_valid = 0 throughout.
- s0 = 0xFF, s1 = 0x01, cin = 0 -> next cycle: sum = 0x00, cout = 1, zero = 1, overflow = 0, out_valid = 1.
- s0 = 0x7F, s1 = 0x01, cin = 0 -> sum = 0x80, cout = 0, overflow = 1. Then s0 = 0x80, s1 = 0x80, cin = 0 -> sum = 0x00, cout = 1, overflow = 1, zero = 1.
- s0 = 0xFF, s1 = 0xFF, cin = 1 -> sum = 0xFF, cout = 1, overflow = 0. Then s0 = 0x12, s1 = 0x34, cin = 1 -> sum = 0x47, cout = 0.
- Random s0/s1/cin streamed back-to-back for 1000 cycles with in_valid toggled randomly -> each result matches the (WIDTH+1)-bit model one cycle later. When in_valid = 0, out_valid = 0 and the previous result values hold.
- Assert rst in the same cycle as a valid input (s0 = 0x01, s1 = 0x01) -> no out_valid the next cycle and outputs are 0. The next valid input (0x03 + 0x04) -> sum = 0x07 one cycle later.

Source files
------------

// File: rtl/full_adder_8bits.sv
// Registered WIDTH-bit ripple-carry adder: {cout, sum} = s0 + s1 + cin, with
// signed-overflow and zero flags, one output register stage qualified by out_valid.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module full_adder_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] s0,
  input  logic [WIDTH-1:0] s1,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (s0[i]),
      .b  (s1[i]),
      .ci (carry[i]),
      .s  (sum_c[i]),
      .co (carry[i+1])
    );
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign cout_c = carry[WIDTH];
  assign ovf_c  = carry[WIDTH] ^ carry[WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  // Results only load on in_valid, so X operands on idle cycles never reach
  // the outputs; an op sampled together with rst is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= sum_c;
      cout      <= cout_c;
      overflow  <= ovf_c;
      zero      <= (sum_c == '0);
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_adder_8bits.sv
// Self-checking bench for full_adder_8bits: directed vector table covering reset,
// carry/overflow corners and mid-stream reset, then a random scoreboard stream.

module tb_full_adder_8bits;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] s0;
  logic [7:0] s1;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       overflow;
  logic       zero;
  logic       out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  full_adder_8bits #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .s0        (s0),
    .s1        (s1),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       in_valid;
    logic [7:0] s0;
    logic [7:0] s1;
    logic       cin;
    logic       exp_valid;
    logic       exp_zero;
    logic       exp_ovf;
    logic       exp_cout;
    logic [7:0] exp_sum;
  } vec_t;

  vec_t vecs[13];
  logic [11:0] exp_q[$];

  // Packed observation: {out_valid, zero, overflow, cout, sum}
  function automatic logic [11:0] observed();
    return {out_valid, zero, overflow, cout, sum};
  endfunction

  task automatic check(input string name, input logic [11:0] actual, input logic [11:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got v=%b z=%b o=%b c=%b sum=%h, expected v=%b z=%b o=%b c=%b sum=%h",
               name, actual[11], actual[10], actual[9], actual[8], actual[7:0],
               expected[11], expected[10], expected[9], expected[8], expected[7:0]);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    rst      = r;
    in_valid = v;
    s0       = a;
    s1       = b;
    cin      = c;
  endtask

  initial begin
    logic [7:0] m_sum;
    logic       m_cout;
    logic       m_ovf;
    logic       m_zero;

    //          rst  v     s0     s1     cin   ev    ez    eo    ec    esum
    vecs[0]  = '{1'b1, 1'b1, 8'h55, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80};
    vecs[4]  = '{1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
    vecs[7]  = '{1'b0, 1'b1, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h47};
    vecs[8]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h47};
    vecs[9]  = '{1'b0, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80};
    vecs[10] = '{1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 8'h03, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07};
    vecs[12] = '{1'b0, 1'b0, 8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07};

    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].in_valid, vecs[i].s0, vecs[i].s1, vecs[i].cin);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), observed(),
            {vecs[i].exp_valid, vecs[i].exp_zero, vecs[i].exp_ovf, vecs[i].exp_cout, vecs[i].exp_sum});
    end

    // Hand-written back-to-back sequence: results must follow one per cycle, in order.
    drive(1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
    @(posedge clk);
    #1;
    check("b2b_first", observed(), {1'b1, 1'b0, 1'b0, 1'b0, 8'h03});
    drive(1'b0, 1'b1, 8'hF0, 8'h10, 1'b0);
    @(posedge clk);
    #1;
    check("b2b_second", observed(), {1'b1, 1'b1, 1'b0, 1'b1, 8'h00});

    // Random stream with scoreboard; model state starts at the last held result.
    m_sum  = 8'h00;
    m_cout = 1'b1;
    m_ovf  = 1'b0;
    m_zero = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic       v;
      logic [8:0] full;
      int         sv;
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      drive(1'b0, v, a, b, c);
      if (v) begin
        full   = {1'b0, a} + {1'b0, b} + {8'h00, c};
        sv     = int'($signed(a)) + int'($signed(b)) + int'(c);
        m_sum  = full[7:0];
        m_cout = full[8];
        m_ovf  = (sv > 127) || (sv < -128);
        m_zero = (full[7:0] == 8'h00);
      end
      exp_q.push_back({v, m_zero, m_ovf, m_cout, m_sum});
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", n), observed(), exp_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
